// File: rtl/m_axil_master_if.sv
// Bundle of the command/response side and the five AXI4-Lite channels of
// m_axil_master. The master modport is the DUT view; slave is the far side.
interface m_axil_master_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_W-1:0]     cmd_addr;
    logic [DATA_W-1:0]     cmd_wdata;
    logic [DATA_W/8-1:0]   cmd_wstrb;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_W-1:0]     rsp_rdata;
    logic [1:0]            rsp_resp;
    logic [ADDR_W-1:0]     AWADDR;
    logic                  AWVALID;
    logic                  AWREADY;
    logic [DATA_W-1:0]     WDATA;
    logic [DATA_W/8-1:0]   WSTRB;
    logic                  WVALID;
    logic                  WREADY;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;
    logic [ADDR_W-1:0]     ARADDR;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [DATA_W-1:0]     RDATA;
    logic [1:0]            RRESP;
    logic                  RVALID;
    logic                  RREADY;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
               AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_resp,
               AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
               AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_resp,
               AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY
    );
endinterface

// File: rtl/m_axil_master.sv
// Single-outstanding AXI4-Lite master: turns one command into one AXI-Lite
// write or read and returns the result on a valid/ready response port.
module m_axil_master #(
    parameter int M_AXI_ADDR_WIDTH = 6,
    parameter int M_AXI_DATA_WIDTH = 32
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    m_axil_master_if.master   bus
);
    localparam int STRB_W = M_AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP
    } state_t;

    state_t                       state_q, state_d;
    logic                         cmd_ready_q, cmd_ready_d;
    logic [M_AXI_ADDR_WIDTH-1:0]  awaddr_q, awaddr_d;
    logic [M_AXI_ADDR_WIDTH-1:0]  araddr_q, araddr_d;
    logic [M_AXI_DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [STRB_W-1:0]            wstrb_q, wstrb_d;
    logic                         awvalid_q, awvalid_d;
    logic                         wvalid_q, wvalid_d;
    logic                         bready_q, bready_d;
    logic                         arvalid_q, arvalid_d;
    logic                         rready_q, rready_d;
    logic                         rsp_valid_q, rsp_valid_d;
    logic [M_AXI_DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic [1:0]                   rsp_resp_q, rsp_resp_d;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        awaddr_d    = awaddr_q;
        araddr_d    = araddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;

        case (state_q)
            IDLE: begin
                // cmd_ready_q gates acceptance so the first cycle after reset ignores commands
                if (bus.cmd_valid && cmd_ready_q) begin
                    if (bus.cmd_addr[1:0] != 2'b00) begin
                        rsp_valid_d = 1'b1;
                        rsp_resp_d  = 2'b10;
                        rsp_rdata_d = '0;
                        state_d     = RESP;
                    end else if (bus.cmd_write) begin
                        awaddr_d  = bus.cmd_addr;
                        wdata_d   = bus.cmd_wdata;
                        wstrb_d   = bus.cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_ADDR_DATA;
                    end else begin
                        araddr_d  = bus.cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = RD_ADDR;
                    end
                end
            end
            WR_ADDR_DATA: begin
                if (awvalid_q && bus.AWREADY) awvalid_d = 1'b0;
                if (wvalid_q && bus.WREADY)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bus.BVALID && bready_q) begin
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_resp_d  = bus.BRESP;
                    rsp_rdata_d = '0;
                    state_d     = RESP;
                end
            end
            RD_ADDR: begin
                // RREADY is raised on entry to RD_DATA so a one-cycle RVALID is never missed
                if (bus.ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (bus.RVALID && rready_q) begin
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_resp_d  = bus.RRESP;
                    rsp_rdata_d = bus.RDATA;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        cmd_ready_d = (state_d == IDLE);
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_resp  = rsp_resp_q;
    assign bus.AWADDR    = awaddr_q;
    assign bus.AWVALID   = awvalid_q;
    assign bus.WDATA     = wdata_q;
    assign bus.WSTRB     = wstrb_q;
    assign bus.WVALID    = wvalid_q;
    assign bus.BREADY    = bready_q;
    assign bus.ARADDR    = araddr_q;
    assign bus.ARVALID   = arvalid_q;
    assign bus.RREADY    = rready_q;
endmodule

// File: tb/tb_m_axil_master.sv
// Directed bench for m_axil_master against a small 16-register AXI-Lite slave model.
module tb_m_axil_master;
    logic ACLK = 1'b0;
    logic ARESETn;
    always #5 ACLK = ~ACLK;

    m_axil_master_if #(.ADDR_W(6), .DATA_W(32)) bus ();

    m_axil_master #(.M_AXI_ADDR_WIDTH(6), .M_AXI_DATA_WIDTH(32)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .bus(bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- slave model ----------------
    logic [31:0] regs [16];
    logic        aw_ready_en = 1'b1;
    logic        b_en = 1'b1;
    logic        aw_have, w_have, bvalid_s, rvalid_s;
    logic [5:0]  aw_addr_s;
    logic [31:0] w_data_s, rdata_s;
    logic [3:0]  w_strb_s;
    logic        aw_ok, w_ok;
    logic [5:0]  wa;
    logic [31:0] wd;
    logic [3:0]  ws;

    assign bus.AWREADY = aw_ready_en;
    assign bus.WREADY  = 1'b1;
    assign bus.ARREADY = 1'b1;
    assign bus.BVALID  = bvalid_s & b_en;
    assign bus.BRESP   = 2'b00;
    assign bus.RVALID  = rvalid_s;
    assign bus.RDATA   = rdata_s;
    assign bus.RRESP   = 2'b00;

    always_comb begin
        aw_ok = aw_have | (bus.AWVALID & bus.AWREADY);
        w_ok  = w_have  | (bus.WVALID & bus.WREADY);
        wa    = aw_have ? aw_addr_s : bus.AWADDR;
        wd    = w_have ? w_data_s : bus.WDATA;
        ws    = w_have ? w_strb_s : bus.WSTRB;
    end

    always @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            aw_have <= 1'b0; w_have <= 1'b0; bvalid_s <= 1'b0; rvalid_s <= 1'b0;
        end else begin
            if (aw_ok && w_ok) begin
                for (int b = 0; b < 4; b++)
                    if (ws[b]) regs[wa[5:2]][8*b +: 8] <= wd[8*b +: 8];
                aw_have <= 1'b0; w_have <= 1'b0; bvalid_s <= 1'b1;
            end else begin
                if (bus.AWVALID && bus.AWREADY) begin aw_have <= 1'b1; aw_addr_s <= bus.AWADDR; end
                if (bus.WVALID && bus.WREADY) begin
                    w_have <= 1'b1; w_data_s <= bus.WDATA; w_strb_s <= bus.WSTRB;
                end
            end
            if (bus.BVALID && bus.BREADY) bvalid_s <= 1'b0;
            if (bus.ARVALID && bus.ARREADY) begin
                rvalid_s <= 1'b1; rdata_s <= regs[bus.ARADDR[5:2]];
            end else if (bus.RVALID && bus.RREADY) rvalid_s <= 1'b0;
        end
    end

    // ---------------- monitors ----------------
    int   rsp_rise = 0, b_hs_cnt = 0, ar_hs_cnt = 0, bus_valid_cycles = 0;
    logic rsp_valid_prev = 1'b0;
    always @(posedge ACLK) begin
        rsp_valid_prev <= bus.rsp_valid;
        if (bus.rsp_valid && !rsp_valid_prev) rsp_rise <= rsp_rise + 1;
        if (bus.BVALID && bus.BREADY) b_hs_cnt <= b_hs_cnt + 1;
        if (bus.ARVALID && bus.ARREADY) ar_hs_cnt <= ar_hs_cnt + 1;
        if (bus.AWVALID || bus.ARVALID) bus_valid_cycles <= bus_valid_cycles + 1;
    end

    // Issue one command, wait (bounded) for its response, acknowledge it.
    task automatic do_cmd(input logic wr, input logic [5:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [31:0] rdata,
                          output logic [1:0] resp, output int lat, output bit ok);
        int n;
        ok = 1'b1; lat = 0; rdata = '0; resp = '0;
        @(negedge ACLK);
        bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = addr;
        bus.cmd_wdata = data; bus.cmd_wstrb = strb;
        n = 0;
        while (!bus.cmd_ready && n < 20) begin @(negedge ACLK); n++; end
        if (!bus.cmd_ready) begin ok = 1'b0; bus.cmd_valid = 1'b0; return; end
        @(negedge ACLK);
        bus.cmd_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 50) begin @(negedge ACLK); lat++; end
        if (!bus.rsp_valid) begin ok = 1'b0; return; end
        rdata = bus.rsp_rdata; resp = bus.rsp_resp;
        $display("txn wr=%0d addr=%h wdata=%h strb=%h -> rdata=%h resp=%0d lat=%0d",
                 wr, addr, data, strb, rdata, resp, lat);
        bus.rsp_ready = 1'b1;
        @(negedge ACLK);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        ARESETn = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0;
        bus.cmd_wdata = '0; bus.cmd_wstrb = '0; bus.rsp_ready = 1'b0;
        repeat (3) @(negedge ACLK);
        n_checks++;
        if ({bus.AWVALID, bus.WVALID, bus.BREADY, bus.ARVALID, bus.RREADY, bus.rsp_valid} !== 6'b0)
            $display("FAIL reset_valids: got %b want 000000",
                     {bus.AWVALID, bus.WVALID, bus.BREADY, bus.ARVALID, bus.RREADY, bus.rsp_valid});
        else n_pass++;
        n_checks++;
        if ({bus.AWADDR, bus.ARADDR, bus.WDATA, bus.WSTRB, bus.rsp_rdata, bus.rsp_resp} !== '0)
            $display("FAIL reset_data: got awaddr=%h araddr=%h wdata=%h wstrb=%h rdata=%h resp=%h want 0",
                     bus.AWADDR, bus.ARADDR, bus.WDATA, bus.WSTRB, bus.rsp_rdata, bus.rsp_resp);
        else n_pass++;
        ARESETn = 1'b1;
        #1;
        n_checks++;
        if (bus.cmd_ready !== 1'b0) $display("FAIL cmd_ready_at_release: got %b want 0", bus.cmd_ready);
        else n_pass++;
        @(negedge ACLK);
        n_checks++;
        if (bus.cmd_ready !== 1'b1) $display("FAIL cmd_ready_after_release: got %b want 1", bus.cmd_ready);
        else n_pass++;
    endtask

    task automatic test_write_read();
        logic [31:0] rd; logic [1:0] rs; int lat; bit ok;
        do_cmd(1'b1, 6'h08, 32'hDEADBEEF, 4'hF, rd, rs, lat, ok);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL wr_done: got %b want 1", ok); else n_pass++;
        n_checks++;
        if ({rs, rd} !== 34'h0) $display("FAIL wr_rsp: got resp=%h rdata=%h want 0/0", rs, rd); else n_pass++;
        n_checks++;
        if (lat !== 3) $display("FAIL wr_latency: got %0d want 3", lat); else n_pass++;
        n_checks++;
        if (bus.AWADDR !== 6'h08 || bus.WDATA !== 32'hDEADBEEF)
            $display("FAIL wr_bus: got awaddr=%h wdata=%h want 08/deadbeef", bus.AWADDR, bus.WDATA);
        else n_pass++;
        do_cmd(1'b0, 6'h08, 32'h0, 4'h0, rd, rs, lat, ok);
        n_checks++;
        if (ok !== 1'b1) $display("FAIL rd_done: got %b want 1", ok); else n_pass++;
        n_checks++;
        if (rd !== 32'hDEADBEEF || rs !== 2'b00)
            $display("FAIL rd_data: got rdata=%h resp=%h want deadbeef/0", rd, rs);
        else n_pass++;
        n_checks++;
        if (lat !== 3) $display("FAIL rd_latency: got %0d want 3", lat); else n_pass++;
        n_checks++;
        if (bus.ARADDR !== 6'h08) $display("FAIL rd_araddr: got %h want 08", bus.ARADDR); else n_pass++;
    endtask

    task automatic test_aw_delay();
        int b0, r0, hold, n;
        b0 = b_hs_cnt; r0 = rsp_rise; hold = 0;
        aw_ready_en = 1'b0;
        @(negedge ACLK);
        n_checks++;
        if (bus.cmd_ready !== 1'b1) $display("FAIL awd_cmd_ready: got %b want 1", bus.cmd_ready); else n_pass++;
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 6'h20;
        bus.cmd_wdata = 32'hA5A55A5A; bus.cmd_wstrb = 4'hF;
        @(negedge ACLK);
        bus.cmd_valid = 1'b0;
        n_checks++;
        if ({bus.AWVALID, bus.WVALID} !== 2'b11)
            $display("FAIL awd_both_valid: got %b want 11", {bus.AWVALID, bus.WVALID});
        else n_pass++;
        if (bus.AWVALID && bus.AWADDR == 6'h20) hold++;
        @(negedge ACLK);
        n_checks++;
        if (bus.WVALID !== 1'b0) $display("FAIL awd_wvalid_drop: got %b want 0", bus.WVALID); else n_pass++;
        if (bus.AWVALID && bus.AWADDR == 6'h20) hold++;
        @(negedge ACLK);
        if (bus.AWVALID && bus.AWADDR == 6'h20) hold++;
        aw_ready_en = 1'b1;
        @(negedge ACLK);
        n_checks++;
        if (bus.AWVALID !== 1'b0 || hold !== 3)
            $display("FAIL awd_aw_hold: got awvalid=%b hold=%0d want 0/3", bus.AWVALID, hold);
        else n_pass++;
        n = 0;
        while (!bus.rsp_valid && n < 20) begin @(negedge ACLK); n++; end
        n_checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_resp !== 2'b00)
            $display("FAIL awd_rsp: got valid=%b resp=%h want 1/0", bus.rsp_valid, bus.rsp_resp);
        else n_pass++;
        $display("txn wr=1 addr=20 wdata=a5a55a5a strb=f (awready delayed) -> resp=%0d", bus.rsp_resp);
        bus.rsp_ready = 1'b1;
        @(negedge ACLK);
        bus.rsp_ready = 1'b0;
        repeat (3) @(negedge ACLK);
        n_checks++;
        if (b_hs_cnt - b0 !== 1 || rsp_rise - r0 !== 1)
            $display("FAIL awd_once: got b_hs=%0d rsp_pulses=%0d want 1/1", b_hs_cnt - b0, rsp_rise - r0);
        else n_pass++;
        n_checks++;
        if (regs[8] !== 32'hA5A55A5A) $display("FAIL awd_slave_reg: got %h want a5a55a5a", regs[8]);
        else n_pass++;
    endtask

    task automatic test_partial();
        logic [31:0] rd; logic [1:0] rs; int lat; bit ok;
        do_cmd(1'b1, 6'h10, 32'hFFFFFFFF, 4'hF, rd, rs, lat, ok);
        do_cmd(1'b1, 6'h10, 32'h00000000, 4'h2, rd, rs, lat, ok);
        do_cmd(1'b0, 6'h10, 32'h0, 4'h0, rd, rs, lat, ok);
        n_checks++;
        if (ok !== 1'b1 || rd !== 32'hFFFF00FF)
            $display("FAIL partial_read: got ok=%b rdata=%h want 1/ffff00ff", ok, rd);
        else n_pass++;
        n_checks++;
        if (regs[4] !== 32'hFFFF00FF) $display("FAIL partial_slave: got %h want ffff00ff", regs[4]);
        else n_pass++;
    endtask

    task automatic test_misaligned();
        logic [31:0] rd; logic [1:0] rs; int lat; bit ok; int v0, b0;
        v0 = bus_valid_cycles; b0 = b_hs_cnt;
        do_cmd(1'b1, 6'h05, 32'h11223344, 4'hF, rd, rs, lat, ok);
        n_checks++;
        if (ok !== 1'b1 || lat !== 1) $display("FAIL mis_latency: got ok=%b lat=%0d want 1/1", ok, lat);
        else n_pass++;
        n_checks++;
        if (rs !== 2'b10 || rd !== 32'h0) $display("FAIL mis_rsp: got resp=%h rdata=%h want 2/0", rs, rd);
        else n_pass++;
        repeat (2) @(negedge ACLK);
        n_checks++;
        if (bus_valid_cycles !== v0 || b_hs_cnt !== b0)
            $display("FAIL mis_no_bus: got valid_cycles=%0d b_hs=%0d want 0/0",
                     bus_valid_cycles - v0, b_hs_cnt - b0);
        else n_pass++;
    endtask

    task automatic test_rsp_backpressure();
        logic [31:0] rd; logic [1:0] rs; int lat; bit ok; int n, bad, a0;
        do_cmd(1'b1, 6'h3C, 32'h12345678, 4'hF, rd, rs, lat, ok);
        @(negedge ACLK);
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 6'h3C;
        @(negedge ACLK);
        bus.cmd_addr = 6'h08;
        n = 0;
        while (!bus.rsp_valid && n < 20) begin @(negedge ACLK); n++; end
        a0 = ar_hs_cnt; bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (!(bus.rsp_valid === 1'b1 && bus.rsp_rdata === 32'h12345678 && bus.cmd_ready === 1'b0)) bad++;
            @(negedge ACLK);
        end
        n_checks++;
        if (bad !== 0) $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); else n_pass++;
        $display("txn wr=0 addr=3c -> rdata=%h resp=%0d (held)", bus.rsp_rdata, bus.rsp_resp);
        bus.rsp_ready = 1'b1;
        @(negedge ACLK);
        bus.rsp_ready = 1'b0;
        n_checks++;
        if ({bus.rsp_valid, bus.cmd_ready, bus.ARVALID} !== 3'b010 || ar_hs_cnt !== a0)
            $display("FAIL bp_no_bypass: got rsp_valid=%b cmd_ready=%b arvalid=%b want 0/1/0",
                     bus.rsp_valid, bus.cmd_ready, bus.ARVALID);
        else n_pass++;
        @(negedge ACLK);
        bus.cmd_valid = 1'b0;
        n_checks++;
        if ({bus.ARVALID, bus.cmd_ready} !== 2'b10 || bus.ARADDR !== 6'h08)
            $display("FAIL bp_second_accept: got arvalid=%b cmd_ready=%b araddr=%h want 1/0/08",
                     bus.ARVALID, bus.cmd_ready, bus.ARADDR);
        else n_pass++;
        n = 0;
        while (!bus.rsp_valid && n < 20) begin @(negedge ACLK); n++; end
        n_checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hDEADBEEF)
            $display("FAIL bp_second_data: got valid=%b rdata=%h want 1/deadbeef", bus.rsp_valid, bus.rsp_rdata);
        else n_pass++;
        $display("txn wr=0 addr=08 -> rdata=%h resp=%0d", bus.rsp_rdata, bus.rsp_resp);
        bus.rsp_ready = 1'b1;
        @(negedge ACLK);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset_abort();
        int n, r0, bad;
        b_en = 1'b0;
        @(negedge ACLK);
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 6'h00;
        bus.cmd_wdata = 32'h00000001; bus.cmd_wstrb = 4'hF;
        @(negedge ACLK);
        bus.cmd_valid = 1'b0;
        n = 0;
        while (!bus.BREADY && n < 20) begin @(negedge ACLK); n++; end
        n_checks++;
        if (bus.BREADY !== 1'b1) $display("FAIL abort_in_wr_resp: got bready=%b want 1", bus.BREADY);
        else n_pass++;
        r0 = rsp_rise;
        @(negedge ACLK);
        ARESETn = 1'b0;
        #1;
        n_checks++;
        if ({bus.AWVALID, bus.WVALID, bus.BREADY, bus.ARVALID, bus.RREADY, bus.rsp_valid, bus.cmd_ready} !== 7'b0)
            $display("FAIL abort_async: got %b want 0000000",
                     {bus.AWVALID, bus.WVALID, bus.BREADY, bus.ARVALID, bus.RREADY, bus.rsp_valid, bus.cmd_ready});
        else n_pass++;
        @(negedge ACLK);
        ARESETn = 1'b1;
        b_en = 1'b1;
        @(negedge ACLK);
        n_checks++;
        if (bus.cmd_ready !== 1'b1) $display("FAIL abort_cmd_ready: got %b want 1", bus.cmd_ready); else n_pass++;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.rsp_valid || bus.BREADY || bus.AWVALID) bad++;
            @(negedge ACLK);
        end
        n_checks++;
        if (bad !== 0 || rsp_rise !== r0)
            $display("FAIL abort_no_rsp: got bad_cycles=%0d rsp_pulses=%0d want 0/0", bad, rsp_rise - r0);
        else n_pass++;
        $display("txn wr=1 addr=00 aborted by reset");
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_aw_delay();
        test_partial();
        test_misaligned();
        test_rsp_backpressure();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
